// File: rtl/rx_lp_ctrl_fsm.sv
// rx_lp_ctrl_fsm: LP-mode control state machine behind the C-PHY LP control decoder.
// Drives the decoder enable and glitch-filters its 2-bit code. It walks the HS entry
// and LP request / yield / turnaround sequences, hands the lane to the HS receiver
// and pulses on protocol errors.
module rx_lp_ctrl_fsm #(
    parameter int unsigned FILTER_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxEnable,
    input  logic [1:0] CtrlDecoderOut,
    input  logic       HsRxDone,
    output logic       CtrlDecoderEn,
    output logic       HsRxEn,
    output logic       StopState,
    output logic       TurnReq,
    output logic       ErrCtrl,
    output logic [2:0] RxState
);

    typedef enum logic [2:0] {
        StStop     = 3'd0,
        StHsRqst   = 3'd1,
        StHsSettle = 3'd2,
        StHsActive = 3'd3,
        StLpRqst   = 3'd4,
        StLpYield  = 3'd5,
        StTaRqst   = 3'd6,
        StWaitStop = 3'd7
    } state_e;

    localparam logic [1:0] CodeStop   = 2'b00;
    localparam logic [1:0] CodeHsRqst = 2'b01;
    localparam logic [1:0] CodeBridge = 2'b10;
    localparam logic [1:0] CodeLpRqst = 2'b11;

    localparam logic [CNT_W-1:0] FiltTarget = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    // Glitch filter state
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             acc_vld_q, acc_vld_d;
    logic [1:0]       acc_q, acc_d;
    logic             evt_q, evt_d;
    logic [1:0]       evt_code_q, evt_code_d;

    // FSM state and settle timer
    state_e           state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    // Registered outputs
    logic       dec_en_q, dec_en_d;
    logic       hs_en_q, hs_en_d;
    logic       stop_q, stop_d;
    logic       turn_q, turn_d;
    logic       err_q, err_d;
    logic [2:0] rxstate_q, rxstate_d;

    assign CtrlDecoderEn = dec_en_q;
    assign HsRxEn        = hs_en_q;
    assign StopState     = stop_q;
    assign TurnReq       = turn_q;
    assign ErrCtrl       = err_q;
    assign RxState       = rxstate_q;

    // Filter next state: only samples taken while the decoder was already enabled count
    always_comb begin
        last_d     = last_q;
        fcnt_d     = fcnt_q;
        acc_vld_d  = acc_vld_q;
        acc_d      = acc_q;
        evt_d      = 1'b0;
        evt_code_d = evt_code_q;
        if (!RxEnable || !dec_en_q) begin
            // Disabled decoder reads 00; forget everything so the next 00 is fresh
            last_d    = CodeStop;
            fcnt_d    = '0;
            acc_vld_d = 1'b0;
            acc_d     = CodeStop;
        end else begin
            last_d = CtrlDecoderOut;
            if ((fcnt_q != '0) && (CtrlDecoderOut == last_q)) begin
                if (fcnt_q < FiltTarget) begin
                    fcnt_d = fcnt_q + CntOne;
                end
            end else begin
                fcnt_d = CntOne;
            end
            if ((fcnt_d >= FiltTarget) && (!acc_vld_q || (acc_q != CtrlDecoderOut))) begin
                acc_vld_d  = 1'b1;
                acc_d      = CtrlDecoderOut;
                evt_d      = 1'b1;
                evt_code_d = CtrlDecoderOut;
            end
        end
    end

    // Filter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= CodeStop;
            fcnt_q     <= '0;
            acc_vld_q  <= 1'b0;
            acc_q      <= CodeStop;
            evt_q      <= 1'b0;
            evt_code_q <= CodeStop;
        end else begin
            last_q     <= last_d;
            fcnt_q     <= fcnt_d;
            acc_vld_q  <= acc_vld_d;
            acc_q      <= acc_d;
            evt_q      <= evt_d;
            evt_code_q <= evt_code_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWaitStop;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // FSM next state; later assignments take priority over earlier ones
    always_comb begin
        state_d = state_q;
        scnt_d  = '0;
        turn_d  = 1'b0;
        err_d   = 1'b0;

        // Settle timer only runs inside HS_SETTLE, so it is zero on entry
        if (state_q == StHsSettle) begin
            scnt_d = scnt_q + CntOne;
            if (scnt_q == SettleLast) begin
                state_d = StHsActive;
            end
        end

        if (evt_q && (state_q != StHsActive)) begin
            unique case (state_q)
                StStop: begin
                    case (evt_code_q)
                        CodeHsRqst: state_d = StHsRqst;
                        CodeLpRqst: state_d = StLpRqst;
                        CodeBridge: begin
                            state_d = StWaitStop;
                            err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StHsRqst: begin
                    case (evt_code_q)
                        CodeBridge: state_d = StHsSettle;
                        CodeLpRqst: begin
                            state_d = StWaitStop;
                            err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StHsSettle: begin
                    if ((evt_code_q == CodeHsRqst) || (evt_code_q == CodeLpRqst)) begin
                        state_d = StWaitStop;
                        err_d   = 1'b1;
                    end
                end
                StLpRqst: begin
                    case (evt_code_q)
                        CodeBridge: state_d = StLpYield;
                        CodeHsRqst: begin
                            state_d = StWaitStop;
                            err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StLpYield: begin
                    case (evt_code_q)
                        CodeLpRqst: state_d = StTaRqst;
                        CodeHsRqst: begin
                            state_d = StWaitStop;
                            err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StTaRqst: begin
                    case (evt_code_q)
                        CodeBridge: begin
                            state_d = StWaitStop;
                            turn_d  = 1'b1;
                        end
                        CodeHsRqst: begin
                            state_d = StWaitStop;
                            err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // WAIT_STOP only leaves on a stop code; HS_ACTIVE is excluded above
                default: ;
            endcase
            // Stop wins over every other event and over settle expiry
            if (evt_code_q == CodeStop) begin
                state_d = StStop;
                turn_d  = 1'b0;
                err_d   = 1'b0;
            end
        end

        if ((state_q == StHsActive) && HsRxDone) begin
            state_d = StWaitStop;
        end

        if (!RxEnable) begin
            state_d = StWaitStop;
            turn_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Output next values derived from the next state so outputs track it with no lag
    always_comb begin
        dec_en_d  = RxEnable && (state_d != StHsActive);
        hs_en_d   = RxEnable && (state_d == StHsActive);
        stop_d    = (state_d == StStop);
        rxstate_d = state_d;
    end

    // Output registers; RxState reads 0 under reset and shows WAIT_STOP after the first edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_en_q  <= 1'b0;
            hs_en_q   <= 1'b0;
            stop_q    <= 1'b0;
            turn_q    <= 1'b0;
            err_q     <= 1'b0;
            rxstate_q <= 3'd0;
        end else begin
            dec_en_q  <= dec_en_d;
            hs_en_q   <= hs_en_d;
            stop_q    <= stop_d;
            turn_q    <= turn_d;
            err_q     <= err_d;
            rxstate_q <= rxstate_d;
        end
    end

endmodule

// File: tb/tb_rx_lp_ctrl_fsm.sv
// tb_rx_lp_ctrl_fsm: vector table, directed corner sequences and random stimulus
// against a queue-based reference model of the LP control FSM.
module tb_rx_lp_ctrl_fsm;

    localparam int FILT   = 2;
    localparam int SETTLE = 8;
    localparam int IGN    = -1;
    localparam int ERR    = -2;
    localparam int TURN   = -3;

    logic       clk;
    logic       rst;
    logic       rxen;
    logic [1:0] code;
    logic       done;
    logic       dec_en;
    logic       hs_en;
    logic       stop_st;
    logic       turn_req;
    logic       err_ctrl;
    logic [2:0] rx_state;

    int total = 0;
    int bad   = 0;

    rx_lp_ctrl_fsm #(
        .FILTER_CYCLES(FILT),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .RxEnable      (rxen),
        .CtrlDecoderOut(code),
        .HsRxDone      (done),
        .CtrlDecoderEn (dec_en),
        .HsRxEn        (hs_en),
        .StopState     (stop_st),
        .TurnReq       (turn_req),
        .ErrCtrl       (err_ctrl),
        .RxState       (rx_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Transition table indexed by [state][accepted code].
    int xt [8][4];
    int hist [$];
    int m_state, m_acc, m_evt, m_settle, m_rx;
    bit m_en, m_hs, m_stop, m_turn, m_err;

    function automatic void model_init_table();
        xt[0] = '{0, 1, ERR, 4};
        xt[1] = '{0, IGN, 2, ERR};
        xt[2] = '{0, ERR, IGN, ERR};
        xt[3] = '{IGN, IGN, IGN, IGN};
        xt[4] = '{0, ERR, 5, IGN};
        xt[5] = '{0, ERR, IGN, 6};
        xt[6] = '{0, ERR, TURN, IGN};
        xt[7] = '{0, IGN, IGN, IGN};
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_state  = 7;
        m_acc    = -1;
        m_evt    = -1;
        m_settle = 0;
        m_rx     = 0;
        m_en     = 0;
        m_hs     = 0;
        m_stop   = 0;
        m_turn   = 0;
        m_err    = 0;
    endfunction

    function automatic void model_edge(bit en, int c, bit d);
        bit was_en;
        int evt;
        int ns;
        int tgt;
        bit same;
        was_en = m_en;
        evt    = m_evt;
        m_evt  = -1;
        m_turn = 0;
        m_err  = 0;
        if (!en || !was_en) begin
            hist.delete();
            m_acc = -1;
        end else begin
            hist.push_back(c);
            if (hist.size() > FILT) void'(hist.pop_front());
            same = (hist.size() == FILT);
            foreach (hist[k]) if (hist[k] != c) same = 0;
            if (same && (m_acc != c)) begin
                m_acc = c;
                m_evt = c;
            end
        end
        ns = m_state;
        if (!en) begin
            ns = 7;
        end else if (m_state == 3) begin
            if (d) ns = 7;
        end else begin
            if ((m_state == 2) && (m_settle + 1 == SETTLE)) ns = 3;
            if (evt >= 0) begin
                tgt = xt[m_state][evt];
                if (tgt == ERR) begin
                    ns    = 7;
                    m_err = 1;
                end else if (tgt == TURN) begin
                    ns     = 7;
                    m_turn = 1;
                end else if (tgt >= 0) begin
                    ns = tgt;
                end
            end
        end
        m_settle = ((m_state == 2) && (ns == 2)) ? m_settle + 1 : 0;
        m_state  = ns;
        m_rx     = ns;
        m_en     = en && (ns != 3);
        m_hs     = (ns == 3);
        m_stop   = (ns == 0);
    endfunction

    function automatic logic [7:0] model_outs();
        logic [2:0] s;
        s = 3'(m_rx);
        return {s, m_en, m_hs, m_stop, m_turn, m_err};
    endfunction

    function automatic logic [7:0] outs();
        return {rx_state, dec_en, hs_en, stop_st, turn_req, err_ctrl};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got st=%0d en=%b hs=%b stop=%b turn=%b err=%b, want st=%0d en=%b hs=%b stop=%b turn=%b err=%b",
                     name, $time, got[7:5], got[4], got[3], got[2], got[1], got[0],
                     exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic drive_edge(input bit en, input logic [1:0] c, input bit d);
        rxen = en;
        code = c;
        done = d;
        @(posedge clk);
        model_edge(en, int'(c), d);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rxen = 1'b1;
        code = 2'b00;
        done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_codes(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            drive_edge(1'b1, c, 1'b0);
            chk("seq_model", outs(), model_outs());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        bit         rxen;
        logic [1:0] code;
        bit         done;
        logic [2:0] st;
        bit         en;
        bit         hs;
        bit         stop;
        bit         turn;
        bit         err;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input int n, input bit r, input logic [1:0] c, input bit d,
                       input logic [2:0] st, input bit en, input bit hs, input bit stop,
                       input bit turn, input bit err);
        vec_t v;
        v = '{r, c, d, st, en, hs, stop, turn, err};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int err_pulses;
        int hs_seen;
        int found;
        int run_left;
        logic [1:0] rc;
        vec_t v;

        rst  = 1'b1;
        rxen = 1'b1;
        code = 2'b00;
        done = 1'b0;
        model_init_table();

        // Reset release, stop entry, full HS burst, LP turnaround, glitch, STOP->bridge error
        //  n  rx code dn  st en hs stop turn err
        add(3, 1, 2'd0, 0, 7, 1, 0, 0, 0, 0);
        add(1, 1, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add(2, 1, 2'd1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 2'd1, 0, 1, 1, 0, 0, 0, 0);
        add(2, 1, 2'd2, 0, 1, 1, 0, 0, 0, 0);
        add(8, 1, 2'd2, 0, 2, 1, 0, 0, 0, 0);
        add(1, 1, 2'd2, 0, 3, 0, 1, 0, 0, 0);
        add(2, 1, 2'd0, 0, 3, 0, 1, 0, 0, 0);
        add(1, 1, 2'd0, 1, 7, 1, 0, 0, 0, 0);
        add(2, 1, 2'd0, 0, 7, 1, 0, 0, 0, 0);
        add(1, 1, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add(2, 1, 2'd3, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 2'd3, 0, 4, 1, 0, 0, 0, 0);
        add(2, 1, 2'd2, 0, 4, 1, 0, 0, 0, 0);
        add(1, 1, 2'd2, 0, 5, 1, 0, 0, 0, 0);
        add(2, 1, 2'd3, 0, 5, 1, 0, 0, 0, 0);
        add(1, 1, 2'd3, 0, 6, 1, 0, 0, 0, 0);
        add(2, 1, 2'd2, 0, 6, 1, 0, 0, 0, 0);
        add(1, 1, 2'd2, 0, 7, 1, 0, 0, 1, 0);
        add(2, 1, 2'd0, 0, 7, 1, 0, 0, 0, 0);
        add(1, 1, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 2'd1, 0, 0, 1, 0, 1, 0, 0);
        add(3, 1, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add(2, 1, 2'd2, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 2'd2, 0, 7, 1, 0, 0, 0, 1);
        add(1, 1, 2'd2, 0, 7, 1, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive_edge(v.rxen, v.code, v.done);
            chk($sformatf("vec%0d", i), outs(), {v.st, v.en, v.hs, v.stop, v.turn, v.err});
            chk($sformatf("vec%0d_model", i), outs(), model_outs());
        end

        // HS_SETTLE interrupted by an LP request: one error pulse, HS never enabled
        do_reset();
        goto_codes(2'd0, 4);
        goto_codes(2'd1, 3);
        goto_codes(2'd2, 3);
        chk_int("settle_entered", int'(rx_state), 2);
        err_pulses = 0;
        hs_seen    = 0;
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b1, 2'd3, 1'b0);
            chk("settle_err_model", outs(), model_outs());
            if (err_ctrl) err_pulses++;
            if (hs_en) hs_seen++;
        end
        chk_int("settle_err_pulses", err_pulses, 1);
        chk_int("settle_hs_never", hs_seen, 0);
        chk_int("settle_err_state", int'(rx_state), 7);

        // HS_ACTIVE, lane disabled: WAIT_STOP with HS and decoder enables off next edge
        do_reset();
        goto_codes(2'd0, 4);
        goto_codes(2'd1, 3);
        goto_codes(2'd2, 11);
        chk_int("active_reached", int'(rx_state), 3);
        drive_edge(1'b0, 2'd0, 1'b0);
        chk("rxen_drop", outs(), {3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        found = 0;
        for (int i = 0; (i < 8) && (found == 0); i++) begin
            drive_edge(1'b1, 2'd0, 1'b0);
            chk("reenable_model", outs(), model_outs());
            if (stop_st) found = 1;
        end
        chk_int("reenable_reaches_stop", found, 1);

        // Async reset in LP_YIELD clears every output before the next edge
        do_reset();
        goto_codes(2'd0, 4);
        goto_codes(2'd3, 3);
        goto_codes(2'd2, 3);
        chk_int("yield_reached", int'(rx_state), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_mid_yield", outs(), 8'h00);
        do_reset();

        // Randomized code runs, occasional lane drops and done pulses
        run_left = 0;
        rc       = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                rc       = 2'($urandom_range(0, 3));
                run_left = $urandom_range(1, 6);
            end
            run_left--;
            drive_edge($urandom_range(0, 99) != 0, rc, $urandom_range(0, 7) == 0);
            chk("random", outs(), model_outs());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
